// File: rtl/dm_sba_v2.sv
// Debug-module system bus access engine: turns sbaddress/sbdata events into single-beat bus cycles.
// Optional watchdog on gnt/r_valid enabled by defining DM_SBA_TIMEOUT_EN.
module dm_sba_v2 #(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   dmactive_i,
  output logic                   master_req_o,
  output logic [AddrWidth-1:0]   master_add_o,
  output logic                   master_we_o,
  output logic [DataWidth-1:0]   master_wdata_o,
  output logic [DataWidth/8-1:0] master_be_o,
  input  logic                   master_gnt_i,
  input  logic                   master_r_valid_i,
  input  logic                   master_r_err_i,
  input  logic [DataWidth-1:0]   master_r_rdata_i,
  input  logic [AddrWidth-1:0]   sbaddress_i,
  input  logic                   sbaddress_write_valid_i,
  input  logic                   sbreadonaddr_i,
  input  logic                   sbreadondata_i,
  input  logic                   sbautoincrement_i,
  input  logic [2:0]             sbaccess_i,
  input  logic [DataWidth-1:0]   sbdata_i,
  input  logic                   sbdata_read_valid_i,
  input  logic                   sbdata_write_valid_i,
  output logic [AddrWidth-1:0]   sbaddress_o,
  output logic                   sbaddress_update_o,
  output logic [DataWidth-1:0]   sbdata_o,
  output logic                   sbdata_valid_o,
  output logic                   sbbusy_o,
  output logic                   sbbusyerror_o,
  input  logic                   sbbusyerror_clear_i,
  output logic [2:0]             sberror_o,
  input  logic                   sberror_clear_i
);

  localparam int unsigned NumBytes = DataWidth / 8;
  localparam int unsigned OffWidth = $clog2(NumBytes);
  localparam logic [2:0]  MaxSize  = 3'($clog2(NumBytes));

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e                state_q, state_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic [2:0]            size_q, size_d;
  logic                  we_q, we_d;
  logic [DataWidth-1:0]  wdata_q, wdata_d;
  logic [NumBytes-1:0]   be_q, be_d;
  logic [2:0]            err_q, err_d, err_new;
  logic                  busyerr_q, busyerr_d;
  logic                  timeout;

  logic [OffWidth-1:0]   off_in, off_q;
  logic [NumBytes-1:0]   be_in, rd_bytes;
  logic [DataWidth-1:0]  rd_mask, rd_shift;
  logic [AddrWidth-1:0]  align_mask;
  logic                  misaligned, wr_trig, rd_trig, any_event, can_trig;

  assign off_in     = sbaddress_i[OffWidth-1:0];
  assign off_q      = addr_q[OffWidth-1:0];
  assign align_mask = (AddrWidth'(1) << sbaccess_i) - AddrWidth'(1);
  assign misaligned = |(sbaddress_i & align_mask);

  assign wr_trig   = sbdata_write_valid_i;
  assign rd_trig   = (sbaddress_write_valid_i & sbreadonaddr_i) |
                     (sbdata_read_valid_i & sbreadondata_i);
  assign any_event = sbaddress_write_valid_i | sbdata_write_valid_i | sbdata_read_valid_i;
  assign can_trig  = (state_q == StIdle) && (err_q == 3'd0) && !busyerr_q;

  // Byte-lane masks: write enables at the trigger address, read mask for the latched size.
  always_comb begin
    be_in    = '0;
    rd_bytes = '0;
    rd_mask  = '0;
    for (int unsigned i = 0; i < NumBytes; i++) begin
      be_in[i]        = (i >= 32'(off_in)) && (i < 32'(off_in) + (32'd1 << sbaccess_i));
      rd_bytes[i]     = i < (32'd1 << size_q);
      rd_mask[8*i +: 8] = {8{rd_bytes[i]}};
    end
  end

  assign rd_shift = master_r_rdata_i >> {off_q, 3'b000};

`ifdef DM_SBA_TIMEOUT_EN
  localparam int unsigned CntWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  assign timeout = (cnt_q == CntWidth'(TimeoutCycles - 1));

  // Restarts on every state change so Req and Wait each get a full budget.
  always_comb begin
    cnt_d = cnt_q + CntWidth'(1);
    if (state_q == StIdle || state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d            = state_q;
    addr_d             = addr_q;
    size_d             = size_q;
    we_d               = we_q;
    wdata_d            = wdata_q;
    be_d               = be_q;
    err_new            = 3'd0;
    busyerr_d          = busyerr_q;
    master_req_o       = 1'b0;
    sbdata_valid_o     = 1'b0;
    sbaddress_update_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (can_trig && (wr_trig || rd_trig)) begin
          if (sbaccess_i > MaxSize) begin
            err_new = 3'd4;
          end else if (misaligned) begin
            err_new = 3'd3;
          end else begin
            state_d = StReq;
            addr_d  = sbaddress_i;
            size_d  = sbaccess_i;
            we_d    = wr_trig;
            wdata_d = sbdata_i << {off_in, 3'b000};
            be_d    = be_in;
          end
        end
      end
      StReq: begin
        master_req_o = 1'b1;
        if (master_gnt_i) begin
          state_d = StWait;
        end else if (timeout) begin
          state_d = StIdle;
          err_new = 3'd1;
        end
      end
      StWait: begin
        if (master_r_valid_i) begin
          state_d = StIdle;
          if (master_r_err_i) begin
            err_new = 3'd2;
          end else begin
            sbdata_valid_o     = !we_q;
            sbaddress_update_o = sbautoincrement_i;
          end
        end else if (timeout) begin
          state_d = StIdle;
          err_new = 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_q != StIdle && any_event) busyerr_d = 1'b1;
    else if (sbbusyerror_clear_i)       busyerr_d = 1'b0;

    // First error sticks; a clear in the same cycle as a new error lets the new one in.
    if (err_new != 3'd0 && (err_q == 3'd0 || sberror_clear_i)) err_d = err_new;
    else if (sberror_clear_i)                                   err_d = 3'd0;
    else                                                        err_d = err_q;

    if (!dmactive_i) begin
      state_d            = StIdle;
      err_d              = 3'd0;
      busyerr_d          = 1'b0;
      sbdata_valid_o     = 1'b0;
      sbaddress_update_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      size_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      be_q      <= '0;
      err_q     <= 3'd0;
      busyerr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      err_q     <= err_d;
      busyerr_q <= busyerr_d;
    end
  end

  assign master_add_o   = addr_q;
  assign master_we_o    = we_q;
  assign master_wdata_o = wdata_q;
  assign master_be_o    = be_q;
  assign sbaddress_o    = sbaddress_update_o ? addr_q + (AddrWidth'(1) << size_q) : '0;
  assign sbdata_o       = sbdata_valid_o ? (rd_shift & rd_mask) : '0;
  assign sbbusy_o       = (state_q != StIdle);
  assign sbbusyerror_o  = busyerr_q;
  assign sberror_o      = err_d;

endmodule

// File: doc/dm_sba_v2.md
# dm_sba_v2

Parametrised second-generation system bus access (SBA) engine for the debug module. It turns debugger sbaddress/sbdata register events into single-beat bus transactions with independent address and data widths. It supports lane-steered read/write data for 8–128-bit accesses and sticky, clearable error reporting for bus errors, misalignment, unsupported size and busy violations. An optional watchdog timeout is also provided. It sits between the DM register file (`dm_csrs`) and the SoC host port.

## Interface
- AddrWidth, 32, width of sbaddress and bus address (≥ 12).
- DataWidth, 32, bus data width; legal values 32, 64, 128.
- TimeoutCycles, 1024, cycles to wait for gnt or r_valid before a timeout error (only with DM_SBA_TIMEOUT_EN).
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- dmactive_i  in  1  synchronous clear when low; returns the FSM to Idle and clears errors.
- master_req_o  out  1  bus request.
- master_add_o  out  AddrWidth  byte address, unaligned as issued.
- master_we_o  out  1  write enable.
- master_wdata_o  out  DataWidth  lane-steered write data.
- master_be_o  out  DataWidth/8  byte enables.
- master_gnt_i  in  1  request accepted.
- master_r_valid_i  in  1  response valid; exactly one per granted request.
- master_r_err_i  in  1  response error, qualified by r_valid.
- master_r_rdata_i  in  DataWidth  read data.
- sbaddress_i  in  AddrWidth  current sbaddress.
- sbaddress_write_valid_i  in  1  debugger wrote sbaddress.
- sbreadonaddr_i, sbreadondata_i, sbautoincrement_i  in  1 each  sbcs control bits.
- sbaccess_i  in  3  log2 of access size in bytes.
- sbdata_i  in  DataWidth  sbdata write value.
- sbdata_read_valid_i, sbdata_write_valid_i  in  1 each  debugger read or write of sbdata0.
- sbaddress_o  out  AddrWidth  incremented address; sbaddress_update_o  out  1  strobe to load it.
- sbdata_o  out  DataWidth  right-aligned, zero-extended read data; sbdata_valid_o  out  1  strobe.
- sbbusy_o  out  1  FSM not Idle.
- sbbusyerror_o  out  1  sticky busy error; sbbusyerror_clear_i  in  1  clear.
- sberror_o  out  3  sticky error code; sberror_clear_i  in  1  clear (W1C from sbcs).

## Operation
- Trigger conditions, evaluated only in Idle:
  - read on sbaddress write when sbreadonaddr_i=1;
  - write on sbdata write;
  - read on sbdata read when sbreadondata_i=1;
  - a write trigger wins over a simultaneous read trigger.
- Triggers are ignored while sberror_o≠0 or sbbusyerror_o=1.
- On trigger, the block latches address, size, we and wdata into registers. Later input changes do not affect the access in flight.
- Pre-checks at trigger; on failure the FSM stays Idle, issues no bus cycle and sets sberror_o:
  - 4 (unsupported size) if sbaccess_i > log2(DataWidth/8);
  - 3 (alignment) if address bits below the size are non-zero.
- States:
  - Idle → Req on a legal trigger.
  - Req: master_req_o=1. Moves to Wait on gnt.
  - Wait: on r_valid, moves to Idle.
- Byte lanes:
  - offset = address mod (DataWidth/8);
  - be = ((1<<(1<<size))−1) << offset;
  - wdata = sbdata_i << 8·offset.
- Read data: sbdata_o = (rdata >> 8·offset), masked to 8·2^size bits.
- Completion without error:
  - sbdata_valid_o pulses for reads only;
  - if sbautoincrement_i=1, sbaddress_update_o pulses with sbaddress_o = addr_q + 2^size, computed modulo 2^AddrWidth (wraps).
- Completion with r_err: sberror_o=2; no sbdata_valid_o; no increment.
- Busy violation: any sbaddress_write_valid_i, sbdata_write_valid_i or sbdata_read_valid_i while not Idle sets sbbusyerror_o. The in-flight access continues and the new event is dropped.
- Error registers:
  - only the first error is recorded; later errors do not overwrite it;
  - a clear and a new error in the same cycle: the new error wins.

## Timing
- Reset values: all outputs 0; sbaddress_o = 0; FSM in Idle.
- Trigger cycle N: master_req_o=1 from cycle N+1 (registered launch).
- master_req_o is held with constant address/we/be/wdata until gnt.
- gnt in the same cycle as req is legal.
- r_valid can arrive in the cycle after gnt at the earliest.
- sbdata_valid_o, sbaddress_update_o and sberror updates are combinational from r_valid, in the same cycle. The FSM is Idle in the next cycle.
- Minimum turnaround from trigger to next acceptable trigger: 3 cycles.
- dmactive_i=0 mid-access: next cycle Idle, req dropped, errors cleared. A late r_valid is ignored while Idle.

## Configuration
- DM_SBA_TIMEOUT_EN defined: a counter runs in Req and Wait and resets on each state entry.
  - Reaching TimeoutCycles → Idle, master_req_o deasserted, sberror_o=1.
  - A later stray r_valid is ignored.
- Not defined: no counter; the block waits indefinitely for gnt or r_valid.

## Test plan
- DataWidth=64: sbaddress=0x1003, sbaccess=0, sbdata write 0xA5 → be=0x08, wdata=0xA5<<24, addr 0x1003; with autoincrement, sbaddress_o=0x1004.
- DataWidth=64: read at 0x2004, size 2, rdata=0x11223344_55667788 → sbdata_o=0x11223344, sbdata_valid_o for 1 cycle.
- Size 1 at address 0x3001 → sberror_o=3, no master_req_o; another trigger is ignored until sberror_clear_i, then accepted.
- DataWidth=32, sbaccess=3 → sberror_o=4; a read with r_err=1 → sberror_o=2, no sbdata_valid_o.
- sbdata write while in Wait → sbbusyerror_o=1, original access completes unchanged; gnt withheld for TimeoutCycles (macro on) → sberror_o=1, Idle.
- AddrWidth=32: autoincrement size 2 from 0xFFFFFFFC → sbaddress_o=0x00000000; dmactive_i low in Req → req drops next cycle.
